data_mem_resp: RTL and testbench

- Responder (memory) end of the CPU memory bus: services the multicycle CPU's load/store requests against an internal word-addressed RAM.
- Each access takes a programmable number of wait states; completion is signalled by a one-cycle ready pulse.
- Sits beside the CPU on the mother board; the controller FSM holds in MEM_READ/MEM_WRITE until ready.

---
 rtl/data_mem_resp.sv | 105 ++++++++++
 tb/tb_data_mem_resp.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_resp.sv
// Memory responder for the CPU bus: word-addressed RAM with programmable wait states and a one-cycle ready pulse.
// Optional MEM_ALIGN_CHK_EN: misaligned byte addresses are rejected like out-of-range ones.
module data_mem_resp #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ready_q;
  logic              err_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-3:0] widx;
  logic [IW-1:0]     idx;
  logic              bad;
  logic              resp_go;
  logic              unused_lo;

  assign widx      = addr_q[ADDR_W-1:2];
  assign idx       = addr_q[IW+1:2];
  assign unused_lo = &{1'b0, addr_q[1:0]};
`ifdef MEM_ALIGN_CHK_EN
  assign bad = (widx >= (ADDR_W-2)'(DEPTH)) || (addr_q[1:0] != 2'b00);
`else
  assign bad = (widx >= (ADDR_W-2)'(DEPTH));
`endif

  // The cycle after sampling is always spent in WAIT, so the pulse lands WAIT_CYCLES+1 edges later.
  assign resp_go = (state_q == WAIT) && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!reset && resp_go && we_q && !bad) mem[idx] <= wdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          if (req) begin
            addr_q  <= addr;
            we_q    <= we;
            wdata_q <= wdata;
            cnt_q   <= CW'(WAIT_CYCLES);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (resp_go) begin
            if (!we_q) rdata_q <= bad ? '0 : mem[idx];
            err_q   <= bad;
            ready_q <= 1'b1;
            state_q <= RESPOND;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESPOND: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = (state_q != IDLE);
  assign ready = ready_q;
  assign err   = err_q;
  assign rdata = rdata_q;
endmodule

// File: tb/tb_data_mem_resp.sv
// Scoreboard bench: stimulus pushes expected responses, monitors pop them on each ready pulse.
module tb_data_mem_resp;
  logic        clk = 1'b0;
  logic        rst2, req2, we2, ready2, busy2, err2;
  logic [31:0] addr2, wdata2, rdata2;
  logic        rst0, req0, we0, ready0, busy0, err0;
  logic [31:0] addr0, wdata0, rdata0;

  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  exp_t q2[$];
  exp_t q0[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_resp #(.DEPTH(64), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(rst2), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
    .rdata(rdata2), .ready(ready2), .busy(busy2), .err(err2));

  data_mem_resp #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst0), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ready2 === 1'b1) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ready2: got ready=1 expected no response");
      end else begin
        e = q2.pop_front();
        chk("mon2_rdata", rdata2, e.rdata);
        chk("mon2_err", {31'b0, err2}, {31'b0, e.err});
      end
    end
    if (ready0 === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ready0: got ready=1 expected no response");
      end else begin
        e = q0.pop_front();
        chk("mon0_rdata", rdata0, e.rdata);
        chk("mon0_err", {31'b0, err0}, {31'b0, e.err});
      end
    end
  end

  // One access on the WAIT_CYCLES=2 instance; inputs are scrambled right after sampling.
  task automatic acc2(input string nm, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err);
    int n;
    @(negedge clk);
    req2 = 1'b1; we2 = w; addr2 = a; wdata2 = d;
    q2.push_back('{exp_rd, exp_err});
    @(posedge clk); #1;
    req2 = 1'b0; we2 = ~w; addr2 = 32'hFFFF_FFFC; wdata2 = 32'hFFFF_FFFF;
    chk({nm, "_busy"}, {31'b0, busy2}, 32'd1);
    n = 0;
    while (ready2 !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, n, 32'd3);
    @(posedge clk); #1;
    chk({nm, "_ready_fall"}, {31'b0, ready2}, 32'd0);
    chk({nm, "_busy_fall"}, {31'b0, busy2}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst2 = 1'b1; req2 = 1'b0; we2 = 1'b0; addr2 = '0; wdata2 = '0;
    rst0 = 1'b1; req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, ready2}, 32'd0);
    chk("rst_busy", {31'b0, busy2}, 32'd0);
    chk("rst_err", {31'b0, err2}, 32'd0);
    chk("rst_rdata", rdata2, 32'd0);
    chk("rst0_busy", {31'b0, busy0}, 32'd0);
    @(negedge clk);
    rst2 = 1'b0; rst0 = 1'b0;

    acc2("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    acc2("rd10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("rdata_hold", rdata2, 32'hDEADBEEF);

    acc2("wr00", 1'b1, 32'h0, 32'h12345678, 32'hDEADBEEF, 1'b0);
    acc2("wr_oor", 1'b1, 32'h100, 32'h1, 32'hDEADBEEF, 1'b1);
    acc2("rd_oor", 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
    acc2("rd00", 1'b0, 32'h0, 32'h0, 32'h12345678, 1'b0);
    acc2("wr20", 1'b1, 32'h20, 32'h5, 32'h12345678, 1'b0);
    acc2("rd20", 1'b0, 32'h20, 32'h0, 32'h5, 1'b0);

    // Abandon a write while still in WAIT.
    @(negedge clk);
    req2 = 1'b1; we2 = 1'b1; addr2 = 32'h20; wdata2 = 32'h77;
    @(posedge clk); #1;
    req2 = 1'b0;
    chk("abort_busy_pre", {31'b0, busy2}, 32'd1);
    @(posedge clk); #1;
    rst2 = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", {31'b0, busy2}, 32'd0);
    chk("abort_ready", {31'b0, ready2}, 32'd0);
    chk("abort_rdata", rdata2, 32'd0);
    rst2 = 1'b0;
    repeat (5) @(posedge clk);
    acc2("rd20_after_abort", 1'b0, 32'h20, 32'h0, 32'h5, 1'b0);

`ifdef MEM_ALIGN_CHK_EN
    acc2("wr_mis", 1'b1, 32'h12, 32'hAB, 32'h5, 1'b1);
    acc2("rd10_mis", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    acc2("rd_mis", 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);
`else
    acc2("wr_mis", 1'b1, 32'h12, 32'hAB, 32'h5, 1'b0);
    acc2("rd10_mis", 1'b0, 32'h10, 32'h0, 32'hAB, 1'b0);
`endif

    // WAIT_CYCLES=0 with req held high across two accesses.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h4; wdata0 = 32'h11;
    q0.push_back('{32'h0, 1'b0});
    q0.push_back('{32'h0, 1'b0});
    @(posedge clk); #1;
    addr0 = 32'h8; wdata0 = 32'h22;
    chk("b2b_busy1", {31'b0, busy0}, 32'd1);
    @(posedge clk); #1;
    chk("b2b_ready1", {31'b0, ready0}, 32'd1);
    @(posedge clk); #1;
    chk("b2b_idle", {31'b0, ready0 | busy0}, 32'd0);
    @(posedge clk); #1;
    chk("b2b_busy2", {31'b0, busy0}, 32'd1);
    req0 = 1'b0; addr0 = 32'h4; wdata0 = 32'h99;
    @(posedge clk); #1;
    chk("b2b_ready2", {31'b0, ready0}, 32'd1);
    @(posedge clk); #1;
    chk("b2b_ready2_fall", {31'b0, ready0}, 32'd0);

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = (i == 0) ? 32'h4 : 32'h8;
      q0.push_back('{(i == 0) ? 32'h11 : 32'h22, 1'b0});
      @(posedge clk); #1;
      req0 = 1'b0;
      @(posedge clk); #1;
      chk("b2b_rd_ready", {31'b0, ready0}, 32'd1);
      @(posedge clk);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("q2_drained", q2.size(), 32'd0);
    chk("q0_drained", q0.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
